tdm_mux4: RTL and testbench



---
 rtl/tdm_pkg.sv | 17 +
 rtl/tdm_chan_buf.sv | 38 +++
 rtl/tdm_mux4.sv | 71 +++++++
 tb/tb_tdm_mux4.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared constants and types for the 4-channel TDM transmit multiplexer.
package tdm_pkg;

  localparam int NCH   = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] slot_t;

  // Counter parks on the last slot so the first tick after reset emits slot 0.
  localparam slot_t SLOT_RESET = 2'd3;

  // Round-robin successor; the 2-bit add wraps 3 -> 0 naturally.
  function automatic slot_t next_slot(input slot_t s);
    return s + slot_t'(1);
  endfunction

endpackage

// File: rtl/tdm_chan_buf.sv
// One-entry holding buffer for a single TDM channel.
// A drain and a load in the same cycle is legal: the held word leaves on the
// shared line while the new word takes its place, so full stays set.
module tdm_chan_buf
  import tdm_pkg::*;
#(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] wr_data,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic         drain,
  output logic [W-1:0] rd_data,
  output logic         full
);

  logic [W-1:0] data_q;

  // Room exists when empty, or when the current word is being drained this cycle.
  assign wr_ready = ~full | drain;
  assign rd_data  = data_q;

  // Load takes priority over drain so a same-cycle swap keeps the buffer occupied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      full   <= 1'b0;
    end else if (wr_valid && wr_ready) begin
      data_q <= wr_data;
      full   <= 1'b1;
    end else if (drain) begin
      full   <= 1'b0;
    end
  end

endmodule

// File: rtl/tdm_mux4.sv
// 4-channel time-division multiplexer (transmit side).
// Fixed round-robin slots, one per slot_tick. Every slot is emitted even when
// its channel has nothing buffered, so the receiver can track position from
// out_sel/frame_sync alone.
module tdm_mux4
  import tdm_pkg::*;
#(
  parameter int W   = 1,
  parameter int NCH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             slot_tick,
  input  logic [NCH*W-1:0] in_data,
  input  logic [NCH-1:0]   in_valid,
  output logic [NCH-1:0]   in_ready,
  output logic [W-1:0]     out_data,
  output slot_t            out_sel,
  output logic             out_valid,
  output logic             frame_sync
);

  // The select tag is 2 bits wide, so only exactly four channels make sense.
  if (NCH != tdm_pkg::NCH) begin : g_nch_check
    $error("tdm_mux4: NCH must be 4");
  end

  slot_t          cnt;
  slot_t          nxt;
  logic [NCH-1:0] full;
  logic [NCH-1:0] drain;
  logic [W-1:0]   rd_data [NCH];

  assign nxt = next_slot(cnt);

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    // A channel drains on the tick that opens its own slot.
    assign drain[gi] = slot_tick & (nxt == slot_t'(gi));

    tdm_chan_buf #(
      .W (W)
    ) u_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_data  (in_data[gi*W +: W]),
      .wr_valid (in_valid[gi]),
      .wr_ready (in_ready[gi]),
      .drain    (drain[gi]),
      .rd_data  (rd_data[gi]),
      .full     (full[gi])
    );
  end

  // Advance the slot and register the outgoing word; everything holds between ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= SLOT_RESET;
      out_sel    <= SLOT_RESET;
      out_data   <= '0;
      out_valid  <= 1'b0;
      frame_sync <= 1'b0;
    end else if (slot_tick) begin
      cnt        <= nxt;
      out_sel    <= nxt;
      frame_sync <= (nxt == slot_t'(0));
      out_valid  <= full[nxt];
      out_data   <= full[nxt] ? rd_data[nxt] : '0;
    end
  end

endmodule

// File: tb/tb_tdm_mux4.sv
// Directed bench for tdm_mux4 (W=1): a vector table for the basic slot
// sequences plus hand-written hold and mid-frame reset sequences. A per-channel
// queue acts as the downstream demux and checks order, loss and duplication.
module tb_tdm_mux4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       slot_tick;
  logic [3:0] in_data;
  logic [3:0] in_valid;
  logic [3:0] in_ready;
  logic [0:0] out_data;
  logic [1:0] out_sel;
  logic       out_valid;
  logic       frame_sync;

  int tests  = 0;
  int failed = 0;

  logic sbq [4][$];

  typedef struct {
    logic       tk;
    logic [3:0] vld;
    logic [3:0] dat;
    logic [3:0] rdy;
    logic [1:0] sel;
    logic       v;
    logic       d;
    logic       fs;
  } vec_t;

  vec_t tbl[$];

  tdm_mux4 #(.W(1), .NCH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .slot_tick  (slot_tick),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_sel    (out_sel),
    .out_valid  (out_valid),
    .frame_sync (frame_sync)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic add(input logic tk, input logic [3:0] vld, input logic [3:0] dat,
                     input logic [3:0] rdy, input logic [1:0] sel,
                     input logic v, input logic d, input logic fs);
    vec_t e;
    e.tk = tk; e.vld = vld; e.dat = dat; e.rdy = rdy;
    e.sel = sel; e.v = v; e.d = d; e.fs = fs;
    tbl.push_back(e);
  endtask

  task automatic chk_outs(input string tag, input logic [1:0] sel, input logic v,
                          input logic d, input logic fs);
    chk({tag, ".out_sel"},    {2'b0, out_sel},    {2'b0, sel});
    chk({tag, ".out_valid"},  {3'b0, out_valid},  {3'b0, v});
    chk({tag, ".out_data"},   {3'b0, out_data},   {3'b0, d});
    chk({tag, ".frame_sync"}, {3'b0, frame_sync}, {3'b0, fs});
  endtask

  // One clock: drive at negedge, check in_ready before the edge, check outputs
  // and the demux scoreboard just after it.
  task automatic step(input string tag, input logic tk, input logic [3:0] vld,
                      input logic [3:0] dat, input logic [3:0] rdy, input logic [1:0] sel,
                      input logic v, input logic d, input logic fs);
    logic [3:0] acc;
    int         ch;
    logic       w;
    @(negedge clk);
    slot_tick = tk;
    in_valid  = vld;
    in_data   = dat;
    #1;
    chk({tag, ".in_ready"}, in_ready, rdy);
    acc = in_valid & in_ready;
    @(posedge clk);
    #1;
    if (tk) begin
      ch = int'(out_sel);
      if (out_valid) begin
        chk({tag, ".sb_word_pending"}, {3'b0, sbq[ch].size() != 0}, 4'd1);
        if (sbq[ch].size() != 0) begin
          w = sbq[ch].pop_front();
          chk({tag, ".sb_word"}, {3'b0, out_data}, {3'b0, w});
        end
      end else begin
        chk({tag, ".sb_no_drop"}, {3'b0, sbq[ch].size() == 0}, 4'd1);
      end
    end
    for (int i = 0; i < 4; i++) if (acc[i]) sbq[i].push_back(dat[i]);
    chk_outs(tag, sel, v, d, fs);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    slot_tick = 1'b0;
    in_valid  = 4'h0;
    in_data   = 4'h0;

    // Test 1: idle frames, sel 0..3 repeating, frame_sync on sel 0
    for (int r = 0; r < 2; r++) begin
      add(1, 4'h0, 4'h0, 4'hf, 2'd0, 0, 0, 1);
      add(1, 4'h0, 4'h0, 4'hf, 2'd1, 0, 0, 0);
      add(1, 4'h0, 4'h0, 4'hf, 2'd2, 0, 0, 0);
      add(1, 4'h0, 4'h0, 4'hf, 2'd3, 0, 0, 0);
    end
    // Test 2: load all four channels (1,0,1,1) without a tick, then emit
    add(0, 4'hf, 4'hd, 4'hf, 2'd3, 0, 0, 0);
    add(1, 4'h0, 4'h0, 4'h1, 2'd0, 1, 1, 1);
    add(1, 4'h0, 4'h0, 4'h3, 2'd1, 1, 0, 0);
    add(1, 4'h0, 4'h0, 4'h7, 2'd2, 1, 1, 0);
    add(1, 4'h0, 4'h0, 4'hf, 2'd3, 1, 1, 0);
    // Test 3: only ch2 offers a 1
    add(1, 4'h4, 4'h4, 4'hf, 2'd0, 0, 0, 1);
    add(1, 4'h0, 4'h0, 4'hb, 2'd1, 0, 0, 0);
    add(1, 4'h0, 4'h0, 4'hf, 2'd2, 1, 1, 0);
    add(1, 4'h0, 4'h0, 4'hf, 2'd3, 0, 0, 0);
    // Test 4: ch1 swap on its own drain tick (old 1 out, new 0 in)
    add(1, 4'h2, 4'h2, 4'hf, 2'd0, 0, 0, 1);
    add(1, 4'h2, 4'h0, 4'hf, 2'd1, 1, 1, 0);
    add(1, 4'h0, 4'h0, 4'hd, 2'd2, 0, 0, 0);
    add(1, 4'h0, 4'h0, 4'hd, 2'd3, 0, 0, 0);
    add(1, 4'h0, 4'h0, 4'hd, 2'd0, 0, 0, 1);
    add(1, 4'h0, 4'h0, 4'hf, 2'd1, 1, 0, 0);

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk_outs("reset", 2'd3, 0, 0, 0);
    chk("reset.in_ready", in_ready, 4'hf);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < tbl.size(); k++)
      step($sformatf("vec%0d", k), tbl[k].tk, tbl[k].vld, tbl[k].dat, tbl[k].rdy,
           tbl[k].sel, tbl[k].v, tbl[k].d, tbl[k].fs);

    // Test 5: load ch2/ch3, then 5 cycles without slot_tick; ch2 offer held while full
    step("hold_load", 0, 4'hc, 4'hc, 4'hf, 2'd1, 1, 0, 0);
    for (int k = 0; k < 5; k++)
      step($sformatf("hold%0d", k), 0, 4'h4, 4'h0, 4'h3, 2'd1, 1, 0, 0);
    step("hold_rel2", 1, 4'h4, 4'h0, 4'h7, 2'd2, 1, 1, 0);
    step("hold_rel3", 1, 4'h0, 4'h0, 4'hb, 2'd3, 1, 1, 0);

    // Test 6: fill every buffer, then reset mid-frame
    step("fill_a", 0, 4'hb, 4'ha, 4'hb, 2'd3, 1, 1, 0);
    step("fill_b", 1, 4'h0, 4'h0, 4'h1, 2'd0, 1, 0, 1);
    step("fill_c", 0, 4'h1, 4'h1, 4'h1, 2'd0, 1, 0, 1);
    @(negedge clk);
    in_valid = 4'h0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_outs("midrst", 2'd3, 0, 0, 0);
    chk("midrst.in_ready", in_ready, 4'hf);
    for (int i = 0; i < 4; i++) sbq[i].delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step("post0", 1, 4'h0, 4'h0, 4'hf, 2'd0, 0, 0, 1);
    step("post1", 1, 4'h0, 4'h0, 4'hf, 2'd1, 0, 0, 0);
    step("post2", 1, 4'h0, 4'h0, 4'hf, 2'd2, 0, 0, 0);
    step("post3", 1, 4'h0, 4'h0, 4'hf, 2'd3, 0, 0, 0);
    step("rec0", 1, 4'hf, 4'h6, 4'hf, 2'd0, 0, 0, 1);
    step("rec1", 1, 4'h0, 4'h0, 4'h2, 2'd1, 1, 1, 0);
    step("rec2", 1, 4'h0, 4'h0, 4'h6, 2'd2, 1, 1, 0);
    step("rec3", 1, 4'h0, 4'h0, 4'he, 2'd3, 1, 0, 0);
    step("rec4", 1, 4'h0, 4'h0, 4'hf, 2'd0, 1, 0, 1);

    for (int i = 0; i < 4; i++)
      chk($sformatf("sb_empty_ch%0d", i), {3'b0, sbq[i].size() == 0}, 4'd1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
